// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   PARITY_NONE / PARITY_ODD / PARITY_EVEN : values accepted by PARITY_MODE
//   rx_state_e                             : receiver FSM state encoding
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync_vote.sv
// Input conditioning for the UART receiver: a 2-flop synchroniser on the raw
// serial line followed by a 3-tap sample history clocked by the oversample tick.
// Ports:
//   clk_50mhz    : system clock
//   rst          : asynchronous active-high reset
//   clock_enable : oversample tick
//   serial_rx    : raw asynchronous serial line
//   line         : synchronised serial line
//   vote         : majority of the two previous tick samples and the current line
module uart_rx_sync_vote (
  input  logic clk_50mhz,
  input  logic rst,
  input  logic clock_enable,
  input  logic serial_rx,
  output logic line,
  output logic vote
);

  logic [1:0] sync_q;
  logic [1:0] taps;

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], serial_rx};
    end
  end

  assign line = sync_q[1];

  // The current line value is the third tap, so on the tick at count
  // OVERSAMPLE/2+1 the vote covers counts OVERSAMPLE/2-1 .. OVERSAMPLE/2+1.
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      taps <= 2'b11;
    end else if (clock_enable) begin
      taps <= {taps[0], line};
    end
  end

  assign vote = (taps[1] & taps[0]) | (taps[1] & line) | (taps[0] & line);

endmodule

// File: rtl/uart_receiver_cfg.sv
// Oversampling UART receiver with configurable word format.
// Ports:
//   clk_50mhz      : system clock
//   rst            : asynchronous active-high reset
//   clock_enable   : oversample tick (OVERSAMPLE per bit)
//   serial_rx      : asynchronous serial input, idles high
//   rx_clear_ready : host acknowledge, clears ready and all error flags
//   data_out       : last received word, LSB first on the wire
//   rx_data_ready  : new word available (level)
//   parity_error   : parity mismatch on data_out
//   framing_error  : a stop bit sampled low
//   overrun_error  : word completed while rx_data_ready was still set
//
// state  | meaning
// IDLE   | waiting for a low line (or for the line to go high after a break)
// START  | confirming the start bit at its vote point
// DATA   | shifting in DATA_BITS voted bits, LSB first
// PARITY | checking the parity bit (skipped when parity is off)
// STOP   | voting stop bits; completes at the last stop bit's vote point
module uart_receiver_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk_50mhz,
  input  logic                 rst,
  input  logic                 clock_enable,
  input  logic                 serial_rx,
  input  logic                 rx_clear_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_data_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun_error
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] VOTE_PT   = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_DONE = 4'(DATA_BITS);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  rx_state_e state, state_next;
  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  logic [3:0] bit_cnt, bit_next;
  logic wait_high, wait_next;
  logic at_vote, at_last;
  logic shift_en, par_chk, stop_chk, complete;

  logic sync_line, vote_bit;
  logic [DATA_BITS-1:0] shreg;
  logic par_acc, par_err_frame, frame_err;

  uart_rx_sync_vote u_sync_vote (
    .clk_50mhz    (clk_50mhz),
    .rst          (rst),
    .clock_enable (clock_enable),
    .serial_rx    (serial_rx),
    .line         (sync_line),
    .vote         (vote_bit)
  );

  assign at_vote = (cnt == VOTE_PT);
  assign at_last = (cnt == LAST_CNT);
  assign cnt_inc = at_last ? '0 : cnt + CW'(1);

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      wait_high <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bit_cnt   <= bit_next;
      wait_high <= wait_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_cnt;
    wait_next  = wait_high;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    stop_chk   = 1'b0;
    complete   = 1'b0;
    if (clock_enable) begin
      case (state)
        IDLE: begin
          cnt_next = '0;
          bit_next = '0;
          if (wait_high) begin
            if (sync_line) wait_next = 1'b0;
          end else if (!sync_line) begin
            state_next = START;
            cnt_next   = CW'(1);
          end
        end
        START: begin
          cnt_next = cnt_inc;
          if (at_vote && vote_bit) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (at_last) begin
            state_next = DATA;
          end
        end
        DATA: begin
          cnt_next = cnt_inc;
          if (at_vote) begin
            shift_en = 1'b1;
            bit_next = bit_cnt + 4'd1;
          end
          if (at_last && bit_cnt == DATA_DONE) begin
            state_next = (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
            bit_next   = '0;
          end
        end
        PARITY: begin
          cnt_next = cnt_inc;
          if (at_vote) par_chk = 1'b1;
          if (at_last) state_next = STOP;
        end
        STOP: begin
          cnt_next = cnt_inc;
          if (at_vote) begin
            stop_chk = 1'b1;
            if (bit_cnt == LAST_STOP) begin
              // Finish at mid-stop so the next start edge is never missed;
              // a low final stop means a possible break, so hold off re-arming.
              complete   = 1'b1;
              state_next = IDLE;
              cnt_next   = '0;
              bit_next   = '0;
              wait_next  = ~vote_bit;
            end else begin
              bit_next = bit_cnt + 4'd1;
            end
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          bit_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      shreg         <= '0;
      par_acc       <= 1'b0;
      par_err_frame <= 1'b0;
      frame_err     <= 1'b0;
    end else if (clock_enable) begin
      if (state == IDLE) begin
        par_acc       <= 1'b0;
        par_err_frame <= 1'b0;
        frame_err     <= 1'b0;
      end
      if (shift_en) begin
        shreg   <= {vote_bit, shreg[DATA_BITS-1:1]};
        par_acc <= par_acc ^ vote_bit;
      end
      if (par_chk) begin
        par_err_frame <= (PARITY_MODE == PARITY_ODD) ? ~(par_acc ^ vote_bit)
                                                     : (par_acc ^ vote_bit);
      end
      if (stop_chk && !vote_bit) frame_err <= 1'b1;
    end
  end

  // Completion takes priority over a simultaneous clear.
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      data_out      <= '0;
      rx_data_ready <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else if (complete) begin
      data_out      <= shreg;
      rx_data_ready <= 1'b1;
      parity_error  <= par_err_frame;
      framing_error <= frame_err | ~vote_bit;
      overrun_error <= rx_data_ready & ~rx_clear_ready;
    end else if (rx_clear_ready) begin
      rx_data_ready <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver_cfg.sv
// Directed bench: instance a is 8N1, instance b is 7E1, both at 16x oversample.
module tb_uart_receiver_cfg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic clr_in = 1'b0;

  logic [7:0] do_a;
  logic       rdy_a, pe_a, fe_a, ov_a;
  logic [6:0] do_b;
  logic       rdy_b, pe_b, fe_b, ov_b;

  int errs = 0;
  int checks = 0;
  int tk = -1;
  int rdy_tk = -1;
  int clr_at = -1;
  int sel = 0;
  logic prev_rdy = 1'b0;

  always #5 clk = ~clk;

  uart_receiver_cfg dut_a (
    .clk_50mhz      (clk),
    .rst            (rst),
    .clock_enable   (ce),
    .serial_rx      (rx_a),
    .rx_clear_ready (clr_in),
    .data_out       (do_a),
    .rx_data_ready  (rdy_a),
    .parity_error   (pe_a),
    .framing_error  (fe_a),
    .overrun_error  (ov_a)
  );

  uart_receiver_cfg #(.DATA_BITS(7), .PARITY_MODE(2)) dut_b (
    .clk_50mhz      (clk),
    .rst            (rst),
    .clock_enable   (ce),
    .serial_rx      (rx_b),
    .rx_clear_ready (clr_in),
    .data_out       (do_b),
    .rx_data_ready  (rdy_b),
    .parity_error   (pe_b),
    .framing_error  (fe_b),
    .overrun_error  (ov_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic cur_rdy();
    return (sel != 0) ? rdy_b : rdy_a;
  endfunction

  // One oversample tick: ce is high for exactly one rising edge.
  task automatic next_tick();
    logic clr;
    clr = (tk + 1 == clr_at);
    repeat (3) @(negedge clk);
    @(negedge clk);
    ce = 1'b1;
    clr_in = clr;
    @(posedge clk);
    #1;
    ce = 1'b0;
    clr_in = 1'b0;
    tk++;
    if (!prev_rdy && cur_rdy() && rdy_tk < 0) rdy_tk = tk;
    prev_rdy = cur_rdy();
  endtask

  task automatic drive_level(input logic lvl, input int n);
    if (sel != 0) rx_b = lvl;
    else rx_a = lvl;
    repeat (n) next_tick();
  endtask

  task automatic send_byte(input logic [8:0] data, input int nb, input bit haspar,
                           input logic parbit, input logic stop_lvl, input int glitch_bit);
    tk = -1;
    rdy_tk = -1;
    prev_rdy = cur_rdy();
    drive_level(1'b0, 16);
    for (int i = 0; i < nb; i++) begin
      if (i == glitch_bit) begin
        drive_level(data[i], 8);
        drive_level(~data[i], 1);
        drive_level(data[i], 7);
      end else begin
        drive_level(data[i], 16);
      end
    end
    if (haspar) drive_level(parbit, 16);
    drive_level(stop_lvl, 16);
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    clr_in = 1'b1;
    @(posedge clk);
    #1;
    clr_in = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_data", do_a, 8'h00);
    chk("rst_rdy", rdy_a, 0);
    chk("rst_pe", pe_a, 0);
    chk("rst_fe", fe_a, 0);
    chk("rst_ov", ov_a, 0);
    drive_level(1'b1, 4);

    // 8N1 0xA5
    sel = 0;
    send_byte(9'h0A5, 8, 0, 1'b0, 1'b1, -1);
    chk("a5_data", do_a, 8'hA5);
    chk("a5_rdy", rdy_a, 1);
    chk("a5_latency", rdy_tk, 153);
    chk("a5_pe", pe_a, 0);
    chk("a5_fe", fe_a, 0);
    chk("a5_ov", ov_a, 0);
    clear_pulse();
    chk("a5_clr_rdy", rdy_a, 0);

    // 7E1: 0x55 has four ones, so parity bit 1 is wrong and 0 is right
    sel = 1;
    send_byte(9'h055, 7, 1, 1'b1, 1'b1, -1);
    chk("p_bad_data", do_b, 7'h55);
    chk("p_bad_pe", pe_b, 1);
    chk("p_bad_latency", rdy_tk, 153);
    chk("p_bad_fe", fe_b, 0);
    clear_pulse();
    chk("p_clr_pe", pe_b, 0);
    send_byte(9'h055, 7, 1, 1'b0, 1'b1, -1);
    chk("p_ok_data", do_b, 7'h55);
    chk("p_ok_pe", pe_b, 0);
    chk("p_ok_rdy", rdy_b, 1);
    clear_pulse();
    rx_b = 1'b1;

    // framing error followed by a break, then a clean frame
    sel = 0;
    send_byte(9'h03C, 8, 0, 1'b0, 1'b0, -1);
    chk("fe_data", do_a, 8'h3C);
    chk("fe_flag", fe_a, 1);
    chk("fe_rdy", rdy_a, 1);
    drive_level(1'b0, 48);
    drive_level(1'b1, 20);
    chk("brk_ov", ov_a, 0);
    chk("brk_data", do_a, 8'h3C);
    clear_pulse();
    chk("brk_clr_fe", fe_a, 0);
    send_byte(9'h081, 8, 0, 1'b0, 1'b1, -1);
    chk("brk_81_data", do_a, 8'h81);
    chk("brk_81_fe", fe_a, 0);
    chk("brk_81_rdy", rdy_a, 1);
    chk("brk_81_ov", ov_a, 0);
    clear_pulse();

    // overrun keeps the newest word
    send_byte(9'h011, 8, 0, 1'b0, 1'b1, -1);
    chk("ov_first_ov", ov_a, 0);
    send_byte(9'h022, 8, 0, 1'b0, 1'b1, -1);
    chk("ov_data", do_a, 8'h22);
    chk("ov_flag", ov_a, 1);
    chk("ov_rdy", rdy_a, 1);
    clear_pulse();
    chk("ov_clr_rdy", rdy_a, 0);
    chk("ov_clr_ov", ov_a, 0);
    chk("ov_clr_fe", fe_a, 0);
    chk("ov_clr_pe", pe_a, 0);
    chk("ov_clr_data", do_a, 8'h22);

    // 4-tick low glitch is a false start
    drive_level(1'b0, 4);
    drive_level(1'b1, 200);
    chk("false_start_rdy", rdy_a, 0);

    // single-tick glitch at count OVERSAMPLE/2 inside data bit 3
    send_byte(9'h05A, 8, 0, 1'b0, 1'b1, 3);
    chk("glitch_data", do_a, 8'h5A);
    chk("glitch_rdy", rdy_a, 1);
    clear_pulse();

    // reset during data bit 3 with a word already pending
    send_byte(9'h033, 8, 0, 1'b0, 1'b1, -1);
    chk("pre_rst_data", do_a, 8'h33);
    drive_level(1'b0, 16);
    drive_level(1'b1, 48);
    drive_level(1'b1, 5);
    rst = 1'b1;
    #1;
    chk("mid_rst_data", do_a, 8'h00);
    chk("mid_rst_rdy", rdy_a, 0);
    chk("mid_rst_ov", ov_a, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev_rdy = 1'b0;
    drive_level(1'b1, 20);
    send_byte(9'h0F0, 8, 0, 1'b0, 1'b1, -1);
    chk("post_rst_data", do_a, 8'hF0);
    chk("post_rst_rdy", rdy_a, 1);
    chk("post_rst_fe", fe_a, 0);
    chk("post_rst_ov", ov_a, 0);

    // clear on the completion tick: completion wins, no overrun
    clr_at = 153;
    send_byte(9'h077, 8, 0, 1'b0, 1'b1, -1);
    clr_at = -1;
    chk("clr_cc_data", do_a, 8'h77);
    chk("clr_cc_rdy", rdy_a, 1);
    chk("clr_cc_ov", ov_a, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
